// File: rtl/pwm_multi_pkg.sv
// Shared command encodings and field positions for the multi-channel PWM controller.
// Purely declarative: no clocked logic, no latency, no backpressure.
package pwm_multi_pkg;

   typedef enum logic [1:0] {
      OP_NOP    = 2'b00,
      OP_DUTY   = 2'b01,
      OP_PERIOD = 2'b10,
      OP_ENABLE = 2'b11
   } op_e;

   localparam int CMD_OP_MSB = 31;
   localparam int CMD_OP_LSB = 30;
   localparam int CMD_CH_LSB = 24;
   localparam int CMD_VAL_LSB = 0;

   function automatic op_e cmd_op(input logic [31:0] cmd);
      return op_e'(cmd[CMD_OP_MSB:CMD_OP_LSB]);
   endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM compare channel: shadowed duty register plus registered output bit.
// Output reflects next-cycle count/enable/duty, so it lines up with the shared counter; no backpressure.
module pwm_compare_ch #(
   parameter int CNT_W = 20
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [CNT_W-1:0] i_value,
   input  logic             i_load,
   input  logic             i_enable_nxt,
   input  logic [CNT_W-1:0] i_count_nxt,
   output logic             o_pwm
);

   logic [CNT_W-1:0] r_duty_pend;
   logic [CNT_W-1:0] r_duty_act;
   logic             r_pwm;
   logic [CNT_W-1:0] w_duty_pend_nxt;
   logic [CNT_W-1:0] w_duty_act_nxt;

   // A write landing on the load edge goes straight into the active duty.
   always_comb begin
      w_duty_pend_nxt = i_wr ? i_value : r_duty_pend;
      w_duty_act_nxt  = i_load ? w_duty_pend_nxt : r_duty_act;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_duty_pend <= '0;
         r_duty_act  <= '0;
         r_pwm       <= 1'b0;
      end else begin
         r_duty_pend <= w_duty_pend_nxt;
         r_duty_act  <= w_duty_act_nxt;
         r_pwm       <= i_enable_nxt && (i_count_nxt < w_duty_act_nxt);
      end
   end

   assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_controller.sv
// Shared-counter PWM controller with shadowed period/duty; outputs registered, commands accepted every cycle.
// PWM_CENTER_ALIGN_EN selects an up/down (centre-aligned) counter; default is an edge-aligned sawtooth.
module pwm_multi_controller
   import pwm_multi_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 20,
   parameter int CH_W   = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [31:0]       command,
   output logic [NUM_CH-1:0] pwm_out,
   output logic [CNT_W-1:0]  count,
   output logic              wrap,
   output logic              cmd_error
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0]  r_count;
   logic [CNT_W-1:0]  r_per_act;
   logic [CNT_W-1:0]  r_per_pend;
   logic [NUM_CH-1:0] r_enable;
   logic              r_wrap;
   logic              r_err;

   op_e               w_op;
   logic [CH_W-1:0]   w_ch;
   logic [CNT_W-1:0]  w_val;
   logic              w_ch_ok;
   logic              w_duty_wr;
   logic              w_per_wr;
   logic              w_en_wr;
   logic              w_err;
   logic [NUM_CH-1:0] w_enable_nxt;
   logic [CNT_W-1:0]  w_per_pend_nxt;
   logic [CNT_W-1:0]  w_per_act_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_valley;
   logic              w_load;
   logic [NUM_CH-1:0] w_pwm;
   logic              w_unused_cmd;

   assign w_op    = cmd_op(command);
   assign w_ch    = command[CMD_CH_LSB +: CH_W];
   assign w_val   = command[CMD_VAL_LSB +: CNT_W];
   assign w_ch_ok = (int'(w_ch) < NUM_CH);

   assign w_duty_wr = cmd_valid && (w_op == OP_DUTY) && w_ch_ok;
   assign w_per_wr  = cmd_valid && (w_op == OP_PERIOD);
   assign w_en_wr   = cmd_valid && (w_op == OP_ENABLE);
   assign w_err     = cmd_valid && (w_op == OP_DUTY) && !w_ch_ok;

   // Field bits between the channel index and the value are don't-care.
   assign w_unused_cmd = ^command;

   assign w_enable_nxt   = w_en_wr ? w_val[NUM_CH-1:0] : r_enable;
   assign w_per_pend_nxt = w_per_wr ? w_val : r_per_pend;
   assign w_per_act_nxt  = w_load ? w_per_pend_nxt : r_per_act;

`ifdef PWM_CENTER_ALIGN_EN
   logic r_dir_dn;
   logic r_first;
   logic w_dir_nxt;

   always_comb begin
      w_cnt_nxt = r_count + CNT_ONE;
      w_valley  = 1'b0;
      w_dir_nxt = r_dir_dn;
      if (r_per_act == '0) begin
         w_cnt_nxt = '0;
         w_valley  = 1'b1;
         w_dir_nxt = 1'b0;
      end else if (!r_dir_dn) begin
         if (r_count >= r_per_act) begin
            w_cnt_nxt = r_per_act - CNT_ONE;
            // With P=1 the step down from the peak already lands in the valley.
            if (r_per_act == CNT_ONE) begin
               w_valley = 1'b1;
            end else begin
               w_dir_nxt = 1'b1;
            end
         end
      end else begin
         w_cnt_nxt = r_count - CNT_ONE;
         if (r_count == CNT_ONE) begin
            w_valley  = 1'b1;
            w_dir_nxt = 1'b0;
         end
      end
   end

   assign w_load = w_valley || r_first;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_dir_dn <= 1'b0;
         r_first  <= 1'b1;
      end else begin
         r_dir_dn <= w_dir_nxt;
         r_first  <= 1'b0;
      end
   end
`else
   always_comb begin
      w_valley  = (r_count == r_per_act);
      w_cnt_nxt = w_valley ? '0 : r_count + CNT_ONE;
   end

   assign w_load = w_valley;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count    <= '0;
         r_per_act  <= '1;
         r_per_pend <= '1;
         r_enable   <= '1;
         r_wrap     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_count    <= w_cnt_nxt;
         r_per_act  <= w_per_act_nxt;
         r_per_pend <= w_per_pend_nxt;
         r_enable   <= w_enable_nxt;
         r_wrap     <= w_valley;
         r_err      <= w_err;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pwm_compare_ch #(
         .CNT_W (CNT_W)
      ) u_ch (
         .i_clk        (clk),
         .i_rst_n      (reset),
         .i_wr         (w_duty_wr && (w_ch == CH_W'(g))),
         .i_value      (w_val),
         .i_load       (w_load),
         .i_enable_nxt (w_enable_nxt[g]),
         .i_count_nxt  (w_cnt_nxt),
         .o_pwm        (w_pwm[g])
      );
   end

   assign pwm_out   = w_pwm;
   assign count     = r_count;
   assign wrap      = r_wrap;
   assign cmd_error = r_err;

endmodule

// File: tb/tb_pwm_multi_controller.sv
// Scoreboard bench: the driver steps a phase-based reference model and queues the expected outputs,
// a negedge monitor pops one entry per clock and compares it with the DUT.
`timescale 1ns/1ps
module tb_pwm_multi_controller;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 8;
   localparam int CH_W   = 6;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              cmd_valid = 1'b0;
   logic [31:0]       command = '0;
   logic [NUM_CH-1:0] pwm_out;
   logic [CNT_W-1:0]  count;
   logic              wrap;
   logic              cmd_error;

   always #5 clk = ~clk;

   pwm_multi_controller #(
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W),
      .CH_W   (CH_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .command   (command),
      .pwm_out   (pwm_out),
      .count     (count),
      .wrap      (wrap),
      .cmd_error (cmd_error)
   );

   typedef struct {
      int unsigned cnt;
      int unsigned pwm;
      bit          wrap;
      bit          err;
   } exp_t;

   exp_t q[$];
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: position within the PWM cycle plus the shadow registers.
   int unsigned m_per, m_per_pend, m_en, m_t;
   int unsigned m_duty[NUM_CH];
   int unsigned m_duty_pend[NUM_CH];
   bit          m_first;

   function automatic int unsigned cyc_len(input int unsigned p);
`ifdef PWM_CENTER_ALIGN_EN
      return (p == 0) ? 1 : 2 * p;
`else
      return p + 1;
`endif
   endfunction

   function automatic int unsigned cnt_of(input int unsigned t, input int unsigned p);
`ifdef PWM_CENTER_ALIGN_EN
      return (t <= p) ? t : 2 * p - t;
`else
      return t + 0 * p;
`endif
   endfunction

   task automatic model_reset();
      m_per      = (1 << CNT_W) - 1;
      m_per_pend = m_per;
      m_en       = (1 << NUM_CH) - 1;
      m_t        = 0;
      m_first    = 1;
      for (int i = 0; i < NUM_CH; i++) begin
         m_duty[i]      = 0;
         m_duty_pend[i] = 0;
      end
   endtask

   task automatic model_step(input bit v, input logic [31:0] c);
      int unsigned op, ch, val;
      bit bnd, ld, err;
      exp_t e;
      op  = c[31:30];
      ch  = c[29:24];
      val = c[CNT_W-1:0];
      bnd = (m_t == cyc_len(m_per) - 1);
      ld  = bnd;
`ifdef PWM_CENTER_ALIGN_EN
      ld = ld || m_first;
`endif
      m_first = 0;
      if (ld) begin
         m_per = m_per_pend;
         for (int i = 0; i < NUM_CH; i++) m_duty[i] = m_duty_pend[i];
      end
      err = 0;
      if (v) begin
         case (op)
            1: if (ch < NUM_CH) begin
                  m_duty_pend[ch] = val;
                  if (ld) m_duty[ch] = val;
               end else begin
                  err = 1;
               end
            2: begin
                  m_per_pend = val;
                  if (ld) m_per = val;
               end
            3: m_en = val & ((1 << NUM_CH) - 1);
            default: ;
         endcase
      end
      m_t    = bnd ? 0 : m_t + 1;
      e.cnt  = cnt_of(m_t, m_per);
      e.wrap = bnd;
      e.err  = err;
      e.pwm  = 0;
      for (int i = 0; i < NUM_CH; i++)
         if (m_en[i] && (e.cnt < m_duty[i])) e.pwm |= (1 << i);
      q.push_back(e);
   endtask

   function automatic logic [31:0] mk(input int unsigned op, input int unsigned ch, input int unsigned val);
      return 32'((op << 30) | ((ch & 63) << 24) | (val & ((1 << CNT_W) - 1)));
   endfunction

   task automatic drive(input bit v, input logic [31:0] c);
      @(negedge clk);
      #1;
      cmd_valid = v;
      command   = c;
      model_step(v, c);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 32'h0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      #1;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      command   = '0;
      model_reset();
      model_step(1'b0, 32'h0);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_count"}, 32'(count), 0);
      chk({tag, "_pwm_out"}, 32'(pwm_out), 0);
      chk({tag, "_wrap"}, 32'(wrap), 0);
      chk({tag, "_cmd_error"}, 32'(cmd_error), 0);
   endtask

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset && (q.size() != 0)) begin
            e = q.pop_front();
            chk("count", 32'(count), e.cnt);
            chk("pwm_out", 32'(pwm_out), e.pwm);
            chk("wrap", 32'(wrap), 32'(e.wrap));
            chk("cmd_error", 32'(cmd_error), 32'(e.err));
         end
      end
   end

   initial begin
      int guard;
      #23;
      check_reset_state("reset");
      release_reset();

      // Duty on ch0 pends until the first 256-clock period ends.
      drive(1'b1, mk(1, 0, 8'h80));
      idle(600);

      // New period and ch2 duty written mid-period; old period runs out first.
      drive(1'b1, mk(2, 0, 9));
      drive(1'b1, mk(1, 2, 3));
      idle(300);

      // Boundary duties, written back to back.
      drive(1'b1, mk(1, 0, 0));
      drive(1'b1, mk(1, 1, 10));
      drive(1'b1, mk(1, 3, 9));
      idle(25);

      // Duty written on the exact boundary edge is active immediately.
      guard = 0;
      while ((m_t != cyc_len(m_per) - 1) && (guard < 400)) begin
         idle(1);
         guard++;
      end
      chk("boundary_reached", 32'(guard < 400), 1);
      drive(1'b1, mk(1, 2, 7));
      idle(15);

      // Invalid channel, then partial enable mask.
      drive(1'b1, mk(1, 5, 1));
      drive(1'b1, mk(3, 0, 4'b0101));
      idle(15);
      drive(1'b1, mk(3, 0, 4'hF));
      idle(5);

      // Short period, duty 2 on ch0.
      drive(1'b1, mk(2, 0, 4));
      drive(1'b1, mk(1, 0, 2));
      drive(1'b1, mk(1, 1, 4));
      idle(30);

      // Reset mid-period with a pending duty.
      drive(1'b1, mk(1, 1, 1));
      idle(2);
      @(negedge clk);
      #1;
      cmd_valid = 1'b0;
      reset     = 1'b0;
      #1;
      check_reset_state("midreset");
      repeat (2) @(negedge clk);
      release_reset();
      idle(300);

      // Randomised traffic with small periods.
      repeat (1500) begin
         if ($urandom_range(0, 9) < 3) begin
            int unsigned op, ch, val;
            op = $urandom_range(0, 3);
            ch = $urandom_range(0, 7);
            case (op)
               2:       val = $urandom_range(0, 12);
               3:       val = $urandom_range(0, 15);
               default: val = $urandom_range(0, 14);
            endcase
            drive(1'b1, mk(op, ch, val));
         end else begin
            idle(1);
         end
      end

      idle(3);
      @(negedge clk);
      #2;
      chk("queue_drained", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
